// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams a contiguous memory range through a small FIFO; MEM_STREAM_READER_CHECKSUM_EN adds a running XOR checksum
module mem_stream_reader #(
   parameter int MAX_MEM_SIZE = 128,
   parameter int DATA_W = 32,
   parameter int ADR_W = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADR_W-1:0]  base_adr,
   input  logic [ADR_W-1:0]  word_cnt,
   output logic [ADR_W-1:0]  rd_adr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]        state;
   logic [ADR_W-1:0]  remaining;
   logic [ADR_W-1:0]  adr_nxt;
   logic [DATA_W-1:0] q_data;
   logic              q_valid;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              accept;
   logic              fetch;
   logic              pop;
   logic              push;
   logic              last_pop;
   assign out_valid = count != '0;
   assign busy = state != IDLE;
   // handshake decodes: a fetch only happens with FIFO room, so the capture register always drains on a fetch
   always_comb begin
      accept = state == IDLE && start;
      fetch = state == FETCH && count < CW'(FIFO_DEPTH);
      pop = out_valid && out_ready;
      push = q_valid && (count < CW'(FIFO_DEPTH) || pop);
      last_pop = state == DRAIN && pop && count == CW'(1) && !q_valid;
      adr_nxt = (rd_adr == ADR_W'(MAX_MEM_SIZE - 1)) ? '0 : rd_adr + ADR_W'(1);
   end
   // burst control: address walk, word countdown and completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rd_adr <= '0;
         remaining <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            rd_adr <= base_adr % ADR_W'(MAX_MEM_SIZE);
            remaining <= word_cnt;
            state <= (word_cnt != '0) ? FETCH : IDLE;
            done <= word_cnt == '0;
         end else if (fetch) begin
            rd_adr <= adr_nxt;
            remaining <= remaining - ADR_W'(1);
            state <= (remaining == ADR_W'(1)) ? DRAIN : FETCH;
         end else if (last_pop) begin
            state <= IDLE;
            done <= 1'b1;
         end
      end
   end
   // read capture register isolates the combinational memory path from the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data <= '0;
      end else if (fetch) begin
         q_valid <= 1'b1;
         q_data <= rd_data;
      end else if (push) begin
         q_valid <= 1'b0;
      end
   end
   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= q_data;
   end
   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // registered head word; holds its last value while the FIFO is empty
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
      end else if (pop) begin
         if (count > CW'(1)) out_data <= mem[rd_ptr + PW'(1)];
         else if (push) out_data <= q_data;
      end else if (count == '0 && push) begin
         out_data <= q_data;
      end
   end
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   // running XOR of consumed words, restarted by each accepted burst
   always_ff @(posedge clk) begin
      if (rst) checksum <= '0;
      else if (accept) checksum <= '0;
      else if (pop) checksum <= checksum ^ out_data;
   end
`endif
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed bench for mem_stream_reader against a preloaded word memory
module tb_mem_stream_reader;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_adr;
   logic [7:0]  word_cnt;
   logic [7:0]  rd_adr;
   logic [31:0] rd_data;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   logic [31:0] checksum;
`endif
   int checks = 0;
   int errors = 0;

   mem_stream_reader dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_adr(base_adr),
      .word_cnt(word_cnt),
      .rd_adr(rd_adr),
      .rd_data(rd_data),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .done(done)
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   assign rd_data = 32'hA000_0000 + {24'd0, rd_adr};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic [7:0] b, input logic [7:0] c);
      base_adr = b;
      word_cnt = c;
      start = 1'b1;
      tick();
      start = 1'b0;
      base_adr = 8'hFF;
      word_cnt = 8'hFF;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      if (rd_adr !== 8'd0) begin errors++; $display("FAIL reset_adr: got %0d expected 0", rd_adr); end
      if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
   endtask

   task automatic test_basic();
      logic ev, eb, ed;
      out_ready = 1'b1;
      start_burst(8'd5, 8'd4);
      for (int k = 0; k < 8; k++) begin
         ev = k >= 2 && k <= 5;
         eb = k <= 5;
         ed = k == 6;
         checks += 3;
         if (out_valid !== ev) begin errors++; $display("FAIL basic_valid k=%0d: got %b expected %b", k, out_valid, ev); end
         if (busy !== eb) begin errors++; $display("FAIL basic_busy k=%0d: got %b expected %b", k, busy, eb); end
         if (done !== ed) begin errors++; $display("FAIL basic_done k=%0d: got %b expected %b", k, done, ed); end
         if (ev) begin
            checks++;
            if (out_data !== 32'hA000_0003 + 32'(k)) begin errors++; $display("FAIL basic_data k=%0d: got %h expected %h", k, out_data, 32'hA000_0003 + 32'(k)); end
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [7:0] adr_tab [5] = '{8'd126, 8'd127, 8'd0, 8'd1, 8'd2};
      logic [31:0] dat_tab [4] = '{32'hA000_007E, 32'hA000_007F, 32'hA000_0000, 32'hA000_0001};
      out_ready = 1'b1;
      start_burst(8'd126, 8'd4);
      for (int k = 0; k < 7; k++) begin
         if (k < 5) begin
            checks++;
            if (rd_adr !== adr_tab[k]) begin errors++; $display("FAIL wrap_adr k=%0d: got %0d expected %0d", k, rd_adr, adr_tab[k]); end
         end
         if (k >= 2 && k <= 5) begin
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid k=%0d: got %b expected 1", k, out_valid); end
            if (out_data !== dat_tab[k-2]) begin errors++; $display("FAIL wrap_data k=%0d: got %h expected %h", k, out_data, dat_tab[k-2]); end
         end
         if (k == 6) begin
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", done); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic rdy_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int idx = 0;
      bit got_done = 0;
      logic prev_v = 1'b0;
      logic prev_pop = 1'b0;
      logic [7:0] adr_hold = '0;
      out_ready = 1'b1;
      start_burst(8'd0, 8'd6);
      for (int k = 0; k < 60 && !got_done; k++) begin
         if (prev_v && !prev_pop) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold k=%0d: got %b expected 1", k, out_valid); end
         end
         if (k == 8) adr_hold = rd_adr;
         if (k == 11) begin
            checks++;
            if (rd_adr !== adr_hold) begin errors++; $display("FAIL bp_stall: got %0d expected %0d", rd_adr, adr_hold); end
         end
         if (done) got_done = 1;
         out_ready = (k < 6) ? rdy_tab[k] : (k >= 11);
         prev_v = out_valid;
         prev_pop = out_valid && out_ready;
         if (prev_pop) begin
            checks++;
            if (out_data !== 32'hA000_0000 + 32'(idx)) begin errors++; $display("FAIL bp_data idx=%0d: got %h expected %h", idx, out_data, 32'hA000_0000 + 32'(idx)); end
            idx++;
         end
         if (!got_done) tick();
      end
      checks += 2;
      if (!got_done) begin errors++; $display("FAIL bp_done: got 0 expected 1 within budget"); end
      if (idx != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", idx); end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_zero_and_ignored_start();
      logic ev, eb, ed;
      out_ready = 1'b1;
      start_burst(8'd3, 8'd0);
      checks += 3;
      if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", out_valid); end
      tick();
      checks += 3;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_done_end: got %b expected 0", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end: got %b expected 0", busy); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_end: got %b expected 0", out_valid); end
      start_burst(8'd20, 8'd2);
      base_adr = 8'd50;
      word_cnt = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 8; k++) begin
         ev = k == 2 || k == 3;
         eb = k <= 3;
         ed = k == 4;
         checks += 3;
         if (out_valid !== ev) begin errors++; $display("FAIL ign_valid k=%0d: got %b expected %b", k, out_valid, ev); end
         if (busy !== eb) begin errors++; $display("FAIL ign_busy k=%0d: got %b expected %b", k, busy, eb); end
         if (done !== ed) begin errors++; $display("FAIL ign_done k=%0d: got %b expected %b", k, done, ed); end
         if (ev) begin
            checks++;
            if (out_data !== 32'hA000_0012 + 32'(k)) begin errors++; $display("FAIL ign_data k=%0d: got %h expected %h", k, out_data, 32'hA000_0012 + 32'(k)); end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      start_burst(8'd0, 8'd8);
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (out_data !== 32'hA000_0002) begin errors++; $display("FAIL mid_pre_data: got %h expected a0000002", out_data); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      if (rd_adr !== 8'd0) begin errors++; $display("FAIL mid_adr: got %0d expected 0", rd_adr); end
      if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks += 2;
         if (done !== 1'b0) begin errors++; $display("FAIL mid_nodone k=%0d: got %b expected 0", k, done); end
         if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_novalid k=%0d: got %b expected 0", k, out_valid); end
      end
      start_burst(8'd10, 8'd1);
      for (int k = 0; k < 5; k++) begin
         checks += 2;
         if (out_valid !== (k == 2)) begin errors++; $display("FAIL post_valid k=%0d: got %b expected %b", k, out_valid, k == 2); end
         if (done !== (k == 3)) begin errors++; $display("FAIL post_done k=%0d: got %b expected %b", k, done, k == 3); end
         if (k == 2) begin
            checks++;
            if (out_data !== 32'hA000_000A) begin errors++; $display("FAIL post_data: got %h expected a000000a", out_data); end
         end
         tick();
      end
   endtask

`ifdef MEM_STREAM_READER_CHECKSUM_EN
   task automatic test_checksum();
      out_ready = 1'b1;
      start_burst(8'd1, 8'd3);
      for (int k = 0; k < 5; k++) tick();
      checks += 2;
      if (done !== 1'b1) begin errors++; $display("FAIL csum_done: got %b expected 1", done); end
      if (checksum !== 32'hA000_0000) begin errors++; $display("FAIL csum_value: got %h expected a0000000", checksum); end
      tick();
      checks++;
      if (checksum !== 32'hA000_0000) begin errors++; $display("FAIL csum_stable: got %h expected a0000000", checksum); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_adr = '0;
      word_cnt = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_and_ignored_start();
      test_reset_mid();
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
